// File: rtl/imm_gen_stage.sv
// Registered ID-stage immediate generator with valid/ready on both sides.
// The output register is backed by one skid entry, so in_ready depends only
// on registered state and never on out_ready.
module imm_gen_stage #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_ill
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_OP_32    = 7'b0111011,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opc_e;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  fmt_e        dec_fmt;
  logic        dec_ill;
  logic [31:0] imm32;
  entry_t      new_entry;
  logic        accept;

  // Format classification from the opcode field
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (in_inst[6:0])
      OPC_OP, OPC_OP_32:                             dec_fmt = FMT_NONE;
      OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR:  dec_fmt = FMT_I;
      OPC_STORE:                                     dec_fmt = FMT_S;
      OPC_BRANCH:                                    dec_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                            dec_fmt = FMT_U;
      OPC_JAL:                                       dec_fmt = FMT_J;
      OPC_SYSTEM: if (EN_ZIMM && in_inst[14])        dec_fmt = FMT_Z;
      default:                                       dec_ill = 1'b1;
    endcase
  end

  // 32-bit immediate per format; zimm has bit 31 clear, so one sign-extend covers all
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
      FMT_U: imm32 = {in_inst[31:12], 12'h000};
      FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
      FMT_Z: imm32 = {27'b0, in_inst[19:15]};
      default: imm32 = '0;
    endcase
    new_entry      = '0;
    new_entry.inst = in_inst;
    new_entry.pc   = in_pc;
    new_entry.imm  = XLEN'(signed'(imm32));
    new_entry.fmt  = dec_fmt;
    new_entry.ill  = dec_ill;
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;

  // Output/skid occupancy: skid only fills while the output is held, and it
  // always refills the output first when the output frees up
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_q.inst;
  assign out_pc    = out_q.pc;
  assign out_imm   = out_q.imm;
  assign out_fmt   = out_q.fmt;
  assign out_ill   = out_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: decode vector table, backpressure,
// flush and reset sequences, and a randomized run against a reference model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready, out_ill;
  logic [31:0] in_inst, out_inst;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [2:0]  out_fmt;

  logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_out_ill;
  logic [31:0] v_in_inst, v_out_inst, v_in_pc, v_out_pc, v_out_imm;
  logic [2:0]  v_out_fmt;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(64), .ILEN(32), .EN_ZIMM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_ill(out_ill)
  );

  imm_gen_stage #(.XLEN(32), .ILEN(32), .EN_ZIMM(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_inst(v_in_inst), .in_pc(v_in_pc),
    .out_valid(v_out_valid), .out_ready(v_out_ready), .out_inst(v_out_inst), .out_pc(v_out_pc),
    .out_imm(v_out_imm), .out_fmt(v_out_fmt), .out_ill(v_out_ill)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  // Reference decode: immediates as signed integer offsets built arithmetically
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [63:0] pc);
    exp_t   e;
    longint v;
    v = 0;
    e.inst = inst; e.pc = pc; e.fmt = 3'd0; e.ill = 1'b0;
    case (inst[6:0])
      7'h33, 7'h3B: e.fmt = 3'd0;
      7'h13, 7'h1B, 7'h03, 7'h67: begin
        e.fmt = 3'd1;
        v = longint'(inst[31:20]);
        if (inst[31]) v -= 4096;
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
        if (inst[31]) v -= 4096;
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2 + longint'(inst[7]) * 2048;
        if (inst[31]) v -= 4096;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = longint'(inst[30:12]) * 4096;
        if (inst[31]) v -= longint'(1) << 31;
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048 + longint'(inst[19:12]) * 4096;
        if (inst[31]) v -= longint'(1) << 20;
      end
      7'h73: if (inst[14]) begin
        e.fmt = 3'd6;
        v = longint'(inst[19:15]);
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = v;
    return e;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t        vecs[12];
  exp_t        q[$];
  exp_t        e;
  logic [6:0]  ops[14];
  logic [31:0] got[3];
  logic [31:0] r, prev_inst;
  logic [63:0] prev_imm;
  logic        hold_prev, acc;
  int          n, cycles, accepted;

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
    vecs[2]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0};
    vecs[3]  = '{32'h3002D073, 64'h5,                   3'd6, 1'b0};
    vecs[4]  = '{32'h0000007F, 64'h0,                   3'd0, 1'b1};
    vecs[5]  = '{32'h00000033, 64'h0,                   3'd0, 1'b0};
    vecs[6]  = '{32'hFE112C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0};
    vecs[7]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
    vecs[8]  = '{32'h30029073, 64'h0,                   3'd0, 1'b0};
    vecs[9]  = '{32'h12345097, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
    vecs[10] = '{32'h7FF00067, 64'h7FF,                 3'd1, 1'b0};
    vecs[11] = '{32'h0000000F, 64'h0,                   3'd0, 1'b1};
    ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h0F};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    v_in_valid = 1'b0; v_out_ready = 1'b0; v_in_inst = '0; v_in_pc = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_out_ill", out_ill, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Decode table at full throughput, one-cycle latency
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      in_inst = vecs[i].inst; in_pc = 64'h1000 + 64'(i * 4);
      @(negedge clk); #1;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_inst", out_inst, vecs[i].inst);
      chk("tbl_pc", out_pc, 64'h1000 + 64'(i * 4));
      chk("tbl_imm", out_imm, vecs[i].imm);
      chk("tbl_fmt", out_fmt, vecs[i].fmt);
      chk("tbl_ill", out_ill, vecs[i].ill);
      in_valid = 1'b0;
    end

    // XLEN=32 build
    @(negedge clk);
    v_in_valid = 1'b1; v_out_ready = 1'b1; v_in_inst = 32'hFE000EE3; v_in_pc = 32'h80;
    @(negedge clk);
    v_in_inst = 32'hFFF00093;
    #1;
    chk("x32_valid", v_out_valid, 1);
    chk("x32_beq_imm", v_out_imm, 32'hFFFF_FFFC);
    chk("x32_beq_fmt", v_out_fmt, 3);
    @(negedge clk);
    v_in_valid = 1'b0;
    #1;
    chk("x32_addi_imm", v_out_imm, 32'hFFFF_FFFF);
    chk("x32_addi_fmt", v_out_fmt, 1);
    @(negedge clk);

    // Backpressure: A, B held, C stalls, then released in order
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00A00093; in_pc = 64'h2000;
    @(negedge clk); #1;
    chk("bp_ready_c1", in_ready, 1);
    chk("bp_out_a", out_inst, 32'h00A00093);
    in_inst = 32'h00B00093;
    @(negedge clk); #1;
    chk("bp_ready_c2", in_ready, 0);
    in_inst = 32'h00C00093;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_hold_a", out_inst, 32'h00A00093);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      if (out_valid && out_ready) begin got[n] = out_inst; n++; end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      #1;
    end
    chk("bp_count", n, 3);
    chk("bp_first", got[0], 32'h00A00093);
    chk("bp_second", got[1], 32'h00B00093);
    chk("bp_third", got[2], 32'h00C00093);
    chk("bp_no_dup", out_valid, 0);
    in_valid = 1'b0;

    // Flush with skid full and a new input offered
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
    @(negedge clk);
    in_inst = 32'h00200093;
    @(negedge clk); #1;
    chk("fl_skid_full", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00300093;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("fl_nothing_after", out_valid, 0);
    end

    // Asynchronous reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h3000;
    @(negedge clk);
    in_inst = 32'h800000B7;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_inst", out_inst, 0);
    chk("mrst_out_imm", out_imm, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("mrst_no_stale", out_valid, 0);
    end

    // Randomized valid/ready traffic against the reference queue
    hold_prev = 1'b0; prev_inst = '0; prev_imm = '0;
    cycles = 0; accepted = 0;
    while (accepted < 10000 && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      in_valid  = ($urandom_range(9) < 7);
      r         = $urandom;
      in_inst   = {r[31:7], ops[$urandom_range(13)]};
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(9) < 6);
      #1;
      if (hold_prev) begin
        chk("rnd_stable_inst", out_inst, prev_inst);
        chk("rnd_stable_imm", out_imm, prev_imm);
      end
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      chk("rnd_out_valid", out_valid, (q.size() > 0));
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_inst", out_inst, e.inst);
        chk("rnd_pc", out_pc, e.pc);
        chk("rnd_imm", out_imm, e.imm);
        chk("rnd_fmt", out_fmt, e.fmt);
        chk("rnd_ill", out_ill, e.ill);
      end
      hold_prev = out_valid && !out_ready;
      prev_inst = out_inst;
      prev_imm  = out_imm;
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_inst, in_pc));
        accepted++;
      end
    end
    if (accepted < 10000) chk("rnd_budget", accepted, 10000);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_inst", out_inst, e.inst);
        chk("drain_imm", out_imm, e.imm);
      end
      @(negedge clk); #1;
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
